// File: rtl/multi_rect_render_if.sv
// Descriptor write port for multi_rect_render.
//   wr_valid  request: write {wr_x, wr_y, wr_w, wr_h, wr_rgb, wr_en} into slot wr_idx
//   wr_ready  slave ready; a write takes effect on a cycle with wr_valid & wr_ready
//   wr_idx    target slot
//   wr_x/y    top-left corner, before origin offset
//   wr_w/h    size; zero in either field leaves the slot empty
//   wr_rgb    {r,g,b}
//   wr_en     slot enable
// Handshake: the master holds wr_valid and the write fields stable until it sees
// wr_valid & wr_ready at a rising clock edge; the slave may drop wr_ready at any
// time, and wr_ready never depends on wr_valid.
interface multi_rect_render_if #(
  parameter int BITS_PER_COLOR = 4,
  parameter int NUM_RECTS      = 4,
  parameter int COORDW         = 16
);
  localparam int IDXW = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;

  logic                        wr_valid;
  logic                        wr_ready;
  logic [IDXW-1:0]             wr_idx;
  logic [COORDW-1:0]           wr_x;
  logic [COORDW-1:0]           wr_y;
  logic [COORDW-1:0]           wr_w;
  logic [COORDW-1:0]           wr_h;
  logic [3*BITS_PER_COLOR-1:0] wr_rgb;
  logic                        wr_en;

  modport master (
    output wr_valid, wr_idx, wr_x, wr_y, wr_w, wr_h, wr_rgb, wr_en,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_idx, wr_x, wr_y, wr_w, wr_h, wr_rgb, wr_en,
    output wr_ready
  );
endinterface

// File: rtl/multi_rect_render.sv
// multi_rect_render: draws up to NUM_RECTS filled rectangles over a background.
// Lower slot index wins on overlap. Descriptors are written into a shadow bank
// and copied to the active bank on frame_start, so a frame never shows a
// half-written scene. Latency from (de, sx, sy) to (de_o, dispcolor_*) is 2.
// Ports:
//   clk_pix, rst_pix_n     pixel clock, asynchronous active-low reset
//   de, sx, sy             data enable and pixel position from timing generator
//   frame_start            one-cycle pulse; commits shadow -> active, blocks writes
//   is_sym_mode            1 = draw scene, 0 = black
//   wr                     descriptor write port (multi_rect_render_if.slave)
//   de_o                   de aligned with the colour outputs
//   dispcolor_r/g/b        registered pixel colour
// Optional build macro: RECT_BORDER_EN -- the first/last row/column of each
// rectangle is drawn with the complement of its colour.
module multi_rect_render #(
  parameter int BITS_PER_COLOR = 4,
  parameter int NUM_RECTS      = 4,
  parameter int COORDW         = 16,
  parameter int ORIGIN_X       = 0,
  parameter int ORIGIN_Y       = 0,
  parameter logic [3*BITS_PER_COLOR-1:0] BG_COLOR = 12'h142
) (
  input  logic                      clk_pix,
  input  logic                      rst_pix_n,
  input  logic                      de,
  input  logic [COORDW-1:0]         sx,
  input  logic [COORDW-1:0]         sy,
  input  logic                      frame_start,
  input  logic                      is_sym_mode,
  multi_rect_render_if.slave        wr,
  output logic                      de_o,
  output logic [BITS_PER_COLOR-1:0] dispcolor_r,
  output logic [BITS_PER_COLOR-1:0] dispcolor_g,
  output logic [BITS_PER_COLOR-1:0] dispcolor_b
);
  localparam int CW = 3 * BITS_PER_COLOR;
  localparam logic [COORDW:0] ORG_X = (COORDW+1)'(ORIGIN_X);
  localparam logic [COORDW:0] ORG_Y = (COORDW+1)'(ORIGIN_Y);
`ifdef RECT_BORDER_EN
  localparam logic [COORDW:0] ONE   = (COORDW+1)'(1);
`endif

  typedef struct packed {
    logic [COORDW-1:0] x;
    logic [COORDW-1:0] y;
    logic [COORDW-1:0] w;
    logic [COORDW-1:0] h;
    logic [CW-1:0]     rgb;
    logic              en;
  } rect_t;

  rect_t shadow [NUM_RECTS];
  rect_t active [NUM_RECTS];

  // Ready is held low for one cycle after reset release and during the
  // commit cycle, so a write can never land in the cycle shadow is copied.
  logic rdy_q;
  logic wr_fire;

  assign wr.wr_ready = rdy_q & ~frame_start;
  assign wr_fire     = wr.wr_valid & wr.wr_ready;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      rdy_q <= 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      // Out-of-range slot indices are accepted and discarded.
      if (wr_fire && (int'(wr.wr_idx) < NUM_RECTS)) begin
        shadow[wr.wr_idx] <= '{x: wr.wr_x, y: wr.wr_y, w: wr.wr_w, h: wr.wr_h,
                               rgb: wr.wr_rgb, en: wr.wr_en};
      end
      if (frame_start) begin
        active <= shadow;
      end
    end
  end

  // Stage 1 compare. Sums are one bit wider than the coordinates so a
  // rectangle running off the right/bottom edge clips instead of wrapping.
  logic [NUM_RECTS-1:0] hit;
  logic [COORDW:0]      x0, x1, y0, y1, sxe, sye;
  logic                 win_any;
  logic [CW-1:0]        win_rgb;
`ifdef RECT_BORDER_EN
  logic [NUM_RECTS-1:0] edge_hit;
  logic                 win_edge;
`endif

  always_comb begin
    hit = '0;
    x0  = '0;
    x1  = '0;
    y0  = '0;
    y1  = '0;
    sxe = {1'b0, sx};
    sye = {1'b0, sy};
`ifdef RECT_BORDER_EN
    edge_hit = '0;
`endif
    for (int i = 0; i < NUM_RECTS; i++) begin
      x0 = ORG_X + {1'b0, active[i].x};
      y0 = ORG_Y + {1'b0, active[i].y};
      x1 = x0 + {1'b0, active[i].w};
      y1 = y0 + {1'b0, active[i].h};
      hit[i] = active[i].en & (sxe >= x0) & (sxe < x1) & (sye >= y0) & (sye < y1);
`ifdef RECT_BORDER_EN
      edge_hit[i] = (sxe == x0) | (sxe == x1 - ONE) | (sye == y0) | (sye == y1 - ONE);
`endif
    end
  end

  // Lowest set index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    win_any = 1'b0;
    win_rgb = '0;
`ifdef RECT_BORDER_EN
    win_edge = 1'b0;
`endif
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_any = 1'b1;
        win_rgb = active[i].rgb;
`ifdef RECT_BORDER_EN
        win_edge = edge_hit[i];
`endif
      end
    end
  end

  // The winning colour is captured in stage 1 so a commit between stages
  // cannot pair one bank's hit with the other bank's colour.
  logic          s1_de;
  logic          s1_mode;
  logic          s1_any;
  logic [CW-1:0] s1_rgb;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      s1_de   <= 1'b0;
      s1_mode <= 1'b0;
      s1_any  <= 1'b0;
      s1_rgb  <= '0;
    end else begin
      s1_de   <= de;
      s1_mode <= is_sym_mode;
      s1_any  <= win_any;
`ifdef RECT_BORDER_EN
      s1_rgb  <= win_edge ? ~win_rgb : win_rgb;
`else
      s1_rgb  <= win_rgb;
`endif
    end
  end

  // Stage 2: blanking, mode and background selection.
  logic [CW-1:0] pix_c;

  always_comb begin
    pix_c = '0;
    if (s1_de && s1_mode) begin
      pix_c = s1_any ? s1_rgb : BG_COLOR;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      de_o        <= 1'b0;
      dispcolor_r <= '0;
      dispcolor_g <= '0;
      dispcolor_b <= '0;
    end else begin
      de_o <= s1_de;
      {dispcolor_r, dispcolor_g, dispcolor_b} <= pix_c;
    end
  end
endmodule

// File: tb/tb_multi_rect_render.sv
// Testbench for multi_rect_render: directed scenes plus randomized writes,
// commits and pixel scans, checked against a behavioural scene model.
module tb_multi_rect_render;
  localparam int NR  = 4;
  localparam int BPC = 4;
  localparam int CWD = 16;
  localparam int OX  = 0;
  localparam int OY  = 0;
  localparam int BG  = 12'h142;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           de, frame_start, is_sym_mode;
  logic [CWD-1:0] sx, sy;
  logic           de_o;
  logic [BPC-1:0] dr, dg, db;

  multi_rect_render_if #(.BITS_PER_COLOR(BPC), .NUM_RECTS(NR), .COORDW(CWD)) wif ();

  multi_rect_render #(
    .BITS_PER_COLOR(BPC), .NUM_RECTS(NR), .COORDW(CWD),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .BG_COLOR(12'h142)
  ) dut (
    .clk_pix(clk), .rst_pix_n(rst_n), .de(de), .sx(sx), .sy(sy),
    .frame_start(frame_start), .is_sym_mode(is_sym_mode), .wr(wif),
    .de_o(de_o), .dispcolor_r(dr), .dispcolor_g(dg), .dispcolor_b(db)
  );

  // scene model
  typedef struct {
    int x; int y; int w; int h; int rgb; bit en;
  } mrect_t;

  mrect_t m_sh [NR];
  mrect_t m_ac [NR];
  bit     m_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] exp_q[$];
  logic [12:0] exp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Colour the scene rules give for a pixel (mode=1, de=1).
  function automatic int model_pix(input int px, input int py);
    for (int i = 0; i < NR; i++) begin
      int ax, ay;
      ax = OX + m_ac[i].x;
      ay = OY + m_ac[i].y;
      if (m_ac[i].en && px >= ax && px < ax + m_ac[i].w && py >= ay && py < ay + m_ac[i].h) begin
`ifdef RECT_BORDER_EN
        if (px == ax || px == ax + m_ac[i].w - 1 || py == ay || py == ay + m_ac[i].h - 1)
          return (~m_ac[i].rgb) & 12'hFFF;
`endif
        return m_ac[i].rgb;
      end
    end
    return BG;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_sh[i] = '{0, 0, 0, 0, 0, 1'b0};
      m_ac[i] = '{0, 0, 0, 0, 0, 1'b0};
    end
    m_rdy = 1'b0;
    exp_q.delete();
  endtask

  // compare process: outputs after the rising edge reflect inputs two edges back
  always @(posedge clk) begin
    #1;
    if (exp_q.size() >= 2) begin
      exp_e = exp_q.pop_front();
      chk("pixel", {19'd0, de_o, dr, dg, db}, {19'd0, exp_e});
    end
  end

  // driver tasks: inputs are set at the falling edge, tick advances one cycle
  task automatic tick(output bit acc);
    bit rdy_exp;
    int idx;
    logic [12:0] e;
    #1;
    rdy_exp = m_rdy && !frame_start;
    chk("wr_ready", 32'(wif.wr_ready), 32'(rdy_exp));
    if (de && is_sym_mode) e = {1'b1, 12'(model_pix(int'(sx), int'(sy)))};
    else e = {de, 12'h000};
    exp_q.push_back(e);
    acc = wif.wr_valid && rdy_exp;
    idx = int'(wif.wr_idx);
    if (acc && idx < NR) begin
      m_sh[idx].x   = int'(wif.wr_x);
      m_sh[idx].y   = int'(wif.wr_y);
      m_sh[idx].w   = int'(wif.wr_w);
      m_sh[idx].h   = int'(wif.wr_h);
      m_sh[idx].rgb = int'(wif.wr_rgb);
      m_sh[idx].en  = wif.wr_en;
    end
    if (frame_start) begin
      for (int i = 0; i < NR; i++) m_ac[i] = m_sh[i];
    end
    m_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_wr(input int idx, input int x, input int y, input int w, input int h,
                        input int rgb, input bit en);
    wif.wr_idx = 2'(idx);
    wif.wr_x   = 16'(x);
    wif.wr_y   = 16'(y);
    wif.wr_w   = 16'(w);
    wif.wr_h   = 16'(h);
    wif.wr_rgb = 12'(rgb);
    wif.wr_en  = en;
  endtask

  task automatic wr(input int idx, input int x, input int y, input int w, input int h,
                    input int rgb, input bit en);
    bit acc;
    int n;
    set_wr(idx, x, y, w, h, rgb, en);
    wif.wr_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 8) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("wr_timeout", 32'd0, 32'd1);
    wif.wr_valid = 1'b0;
  endtask

  task automatic commit();
    bit acc;
    frame_start = 1'b1;
    tick(acc);
    frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    bit acc;
    de = 1'b1;
    sx = 16'(x);
    sy = 16'(y);
    tick(acc);
    de = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int ok;
    rst_n = 1'b0;
    de = 1'b0; sx = '0; sy = '0; frame_start = 1'b0; is_sym_mode = 1'b0;
    wif.wr_valid = 1'b0;
    set_wr(0, 0, 0, 0, 0, 0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_de_o", 32'(de_o), 32'd0);
    chk("reset_color", {20'd0, dr, dg, db}, 32'd0);
    chk("reset_ready", 32'(wif.wr_ready), 32'd0);
    rst_n = 1'b1;
    is_sym_mode = 1'b1;

    // empty scene shows background
    pix(10, 10);
    chk("lit_bg", 32'(model_pix(10, 10)), 32'h142);

    // single rectangle and its boundaries
    wr(0, 50, 50, 20, 10, 12'hF00, 1'b1);
    commit();
    pix(50, 50); pix(69, 59); pix(70, 50); pix(50, 60); pix(55, 55);
`ifdef RECT_BORDER_EN
    chk("lit_corner", 32'(model_pix(50, 50)), 32'h0FF);
    chk("lit_far", 32'(model_pix(69, 59)), 32'h0FF);
`else
    chk("lit_corner", 32'(model_pix(50, 50)), 32'hF00);
    chk("lit_far", 32'(model_pix(69, 59)), 32'hF00);
`endif
    chk("lit_right_out", 32'(model_pix(70, 50)), 32'h142);
    chk("lit_below_out", 32'(model_pix(50, 60)), 32'h142);

    // overlap: slot 0 wins
    wr(1, 60, 55, 20, 20, 12'h0F0, 1'b1);
    commit();
    pix(65, 57); pix(75, 57);
    chk("lit_overlap", 32'(model_pix(65, 57)), 32'hF00);
    chk("lit_slot1", 32'(model_pix(75, 57)), 32'h0F0);

    // shadow write invisible until commit
    wr(0, 50, 50, 20, 10, 12'h00F, 1'b1);
    pix(55, 55);
    chk("lit_pre_commit", 32'(model_pix(55, 55)), 32'hF00);
    commit();
    pix(55, 55);
    chk("lit_post_commit", 32'(model_pix(55, 55)), 32'h00F);

    // write held across frame_start
    set_wr(0, 50, 50, 20, 10, 12'hFF0, 1'b1);
    wif.wr_valid = 1'b1;
    frame_start = 1'b1;
    tick(acc);
    chk("held_blocked", 32'(acc), 32'd0);
    frame_start = 1'b0;
    tick(acc);
    chk("held_accepted", 32'(acc), 32'd1);
    wif.wr_valid = 1'b0;
    pix(55, 55);
    chk("lit_held_old", 32'(model_pix(55, 55)), 32'h00F);
    commit();
    pix(55, 55);
    chk("lit_held_new", 32'(model_pix(55, 55)), 32'hFF0);

    // black screen mode, blanking
    is_sym_mode = 1'b0;
    pix(55, 55);
    is_sym_mode = 1'b1;
    de = 1'b0; sx = 16'd55; sy = 16'd55;
    tick(acc);

    // clipping at the right edge of the coordinate space
    wr(2, 65530, 0, 100, 5, 12'h0AA, 1'b1);
    commit();
    pix(65535, 2); pix(65529, 2); pix(3, 2); pix(0, 2);
    chk("lit_clip_hit", 32'(model_pix(65535, 2)), 32'h0AA);
    chk("lit_clip_nowrap", 32'(model_pix(3, 2)), 32'h142);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      wif.wr_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0)
        set_wr($urandom_range(0, NR - 1), $urandom_range(65500, 65535), $urandom_range(0, 100),
               $urandom_range(0, 60), $urandom_range(0, 40), $urandom_range(0, 4095), 1'b1);
      else
        set_wr($urandom_range(0, NR - 1), $urandom_range(0, 100), $urandom_range(0, 100),
               $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 4095),
               ($urandom_range(0, 4) != 0));
      frame_start = ($urandom_range(0, 19) == 0);
      de = ($urandom_range(0, 7) != 0);
      is_sym_mode = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) sx = 16'($urandom_range(65490, 65535));
      else sx = 16'($urandom_range(0, 140));
      sy = 16'($urandom_range(0, 140));
      tick(acc);
    end
    wif.wr_valid = 1'b0;
    frame_start = 1'b0;
    is_sym_mode = 1'b1;

    // reset in the middle of a drawn rectangle
    wr(0, 50, 50, 20, 10, 12'hFF0, 1'b1);
    commit();
    de = 1'b1; sx = 16'd55; sy = 16'd55;
    tick(acc);
    tick(acc);
    @(posedge clk);
    #2;
    ok = {de_o, dr, dg, db};
    chk("pre_reset_pixel", 32'(ok), 32'h1FF0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", {19'd0, de_o, dr, dg, db}, 32'd0);
    chk("async_reset_ready", 32'(wif.wr_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pix(55, 55);
    chk("lit_after_reset", 32'(model_pix(55, 55)), 32'h142);
    de = 1'b0;
    tick(acc);
    tick(acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
